// File: rtl/min_sopc_if.sv
// Instruction-fetch bus between the CPU core and the instruction ROM.
interface min_sopc_if;
   logic        ce;
   logic [9:0]  addr;
   logic [31:0] inst;

   modport master (output ce, output addr, input inst);
   modport slave  (input ce, input addr, output inst);
endinterface

// File: rtl/min_sopc.sv
// Minimal SoPC: 5-stage MIPS-subset pipeline (IF/ID/EX/MEM/WB) plus instruction ROM.
// Build macro MIN_SOPC_FORWARD_EN: forward EX/MEM/WB results into ID instead of stalling on RAW hazards.

module min_sopc_regfile (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_we,
   input  logic [4:0]  i_waddr,
   input  logic [31:0] i_wdata,
   input  logic [4:0]  i_raddr1,
   output logic [31:0] o_rdata1,
   input  logic [4:0]  i_raddr2,
   output logic [31:0] o_rdata2
);
   logic [31:0] storage [0:31];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 32; i++) storage[i] <= '0;
      end else if (i_we && (i_waddr != 5'd0)) begin
         storage[i_waddr] <= i_wdata;
      end
   end

   // Same-cycle write is visible to readers (WB bypass)
   always_comb begin
      o_rdata1 = storage[i_raddr1];
      if (i_raddr1 == 5'd0)                         o_rdata1 = '0;
      else if (i_we && (i_waddr == i_raddr1))       o_rdata1 = i_wdata;
      o_rdata2 = storage[i_raddr2];
      if (i_raddr2 == 5'd0)                         o_rdata2 = '0;
      else if (i_we && (i_waddr == i_raddr2))       o_rdata2 = i_wdata;
   end
endmodule

module min_sopc_inst_rom (
   min_sopc_if.slave rom
);
   logic [31:0] inst_mem [0:1023];

   assign rom.inst = rom.ce ? inst_mem[rom.addr] : '0;
endmodule

module min_sopc_cpu (
   input logic        i_clk,
   input logic        i_rst,
   min_sopc_if.master rom
);
   typedef enum logic [3:0] {
      ALU_NOP, ALU_OR, ALU_AND, ALU_XOR, ALU_NOR,
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_MUL
   } alu_op_t;

   localparam logic [5:0] OP_SPECIAL  = 6'h00;
   localparam logic [5:0] OP_ANDI     = 6'h0C;
   localparam logic [5:0] OP_ORI      = 6'h0D;
   localparam logic [5:0] OP_XORI     = 6'h0E;
   localparam logic [5:0] OP_LUI      = 6'h0F;
   localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

   logic [31:0] r_pc;
   logic [31:0] r_if_id_inst;
   alu_op_t     r_id_ex_op;
   logic [31:0] r_id_ex_a, r_id_ex_b;
   logic [4:0]  r_id_ex_wd;
   logic        r_id_ex_wreg;
   logic [31:0] r_ex_mem_wdata;
   logic [4:0]  r_ex_mem_wd;
   logic        r_ex_mem_wreg;
   logic [31:0] r_mem_wb_wdata;
   logic [4:0]  r_mem_wb_wd;
   logic        r_mem_wb_wreg;
   logic        r_stall_cnt;

   logic [5:0]  w_opcode, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
   logic [15:0] w_imm;
   alu_op_t     w_aluop;
   logic        w_re1, w_re2, w_wreg;
   logic [4:0]  w_wd;
   logic [31:0] w_imm_ext;
   logic [31:0] w_rdata1, w_rdata2;
   logic [31:0] w_src_a, w_src_b;
   logic [31:0] w_ex_wdata, w_prod;
   logic        w_stall_id, w_stall_ex;

   assign rom.ce   = ~i_rst;
   assign rom.addr = r_pc[11:2];

   assign w_opcode = r_if_id_inst[31:26];
   assign w_rs     = r_if_id_inst[25:21];
   assign w_rt     = r_if_id_inst[20:16];
   assign w_rd     = r_if_id_inst[15:11];
   assign w_shamt  = r_if_id_inst[10:6];
   assign w_funct  = r_if_id_inst[5:0];
   assign w_imm    = r_if_id_inst[15:0];

   // Unrecognised encodings (including R-type with non-zero shamt) decode to NOP
   always_comb begin
      w_aluop   = ALU_NOP;
      w_re1     = 1'b0;
      w_re2     = 1'b0;
      w_wd      = w_rt;
      w_imm_ext = {16'h0000, w_imm};
      case (w_opcode)
         OP_SPECIAL: begin
            w_wd = w_rd;
            if (w_shamt == 5'd0) begin
               case (w_funct)
                  6'h25:   w_aluop = ALU_OR;
                  6'h24:   w_aluop = ALU_AND;
                  6'h26:   w_aluop = ALU_XOR;
                  6'h27:   w_aluop = ALU_NOR;
                  6'h21:   w_aluop = ALU_ADD;
                  6'h23:   w_aluop = ALU_SUB;
                  6'h2A:   w_aluop = ALU_SLT;
                  default: w_aluop = ALU_NOP;
               endcase
            end
            w_re1 = (w_aluop != ALU_NOP);
            w_re2 = (w_aluop != ALU_NOP);
         end
         OP_SPECIAL2: begin
            w_wd = w_rd;
            if ((w_funct == 6'h02) && (w_shamt == 5'd0)) begin
               w_aluop = ALU_MUL;
               w_re1   = 1'b1;
               w_re2   = 1'b1;
            end
         end
         OP_ORI:  begin w_aluop = ALU_OR;  w_re1 = 1'b1; end
         OP_ANDI: begin w_aluop = ALU_AND; w_re1 = 1'b1; end
         OP_XORI: begin w_aluop = ALU_XOR; w_re1 = 1'b1; end
         OP_LUI: begin
            w_aluop   = ALU_OR;
            w_imm_ext = {w_imm, 16'h0000};
         end
         default: w_aluop = ALU_NOP;
      endcase
      w_wreg = (w_aluop != ALU_NOP);
   end

   min_sopc_regfile register (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_we     (r_mem_wb_wreg),
      .i_waddr  (r_mem_wb_wd),
      .i_wdata  (r_mem_wb_wdata),
      .i_raddr1 (w_rs),
      .o_rdata1 (w_rdata1),
      .i_raddr2 (w_rt),
      .o_rdata2 (w_rdata2)
   );

`ifdef MIN_SOPC_FORWARD_EN
   // Youngest producer wins: EX, then MEM, then WB
   always_comb begin
      w_src_a = w_rdata1;
      if (w_rs != 5'd0) begin
         if (r_id_ex_wreg && (r_id_ex_wd == w_rs))         w_src_a = w_ex_wdata;
         else if (r_ex_mem_wreg && (r_ex_mem_wd == w_rs))  w_src_a = r_ex_mem_wdata;
         else if (r_mem_wb_wreg && (r_mem_wb_wd == w_rs))  w_src_a = r_mem_wb_wdata;
      end
      w_src_b = w_rdata2;
      if (w_rt != 5'd0) begin
         if (r_id_ex_wreg && (r_id_ex_wd == w_rt))         w_src_b = w_ex_wdata;
         else if (r_ex_mem_wreg && (r_ex_mem_wd == w_rt))  w_src_b = r_ex_mem_wdata;
         else if (r_mem_wb_wreg && (r_mem_wb_wd == w_rt))  w_src_b = r_mem_wb_wdata;
      end
      w_stall_id = 1'b0;
   end
`else
   // Hold ID until the producer reaches WB, where the regfile bypass covers it
   always_comb begin
      w_src_a    = w_rdata1;
      w_src_b    = w_rdata2;
      w_stall_id = 1'b0;
      if (w_re1 && (w_rs != 5'd0) &&
          ((r_id_ex_wreg && (r_id_ex_wd == w_rs)) || (r_ex_mem_wreg && (r_ex_mem_wd == w_rs))))
         w_stall_id = 1'b1;
      if (w_re2 && (w_rt != 5'd0) &&
          ((r_id_ex_wreg && (r_id_ex_wd == w_rt)) || (r_ex_mem_wreg && (r_ex_mem_wd == w_rt))))
         w_stall_id = 1'b1;
   end
`endif

   assign w_prod = r_id_ex_a * r_id_ex_b;

   always_comb begin
      w_ex_wdata = '0;
      case (r_id_ex_op)
         ALU_OR:  w_ex_wdata = r_id_ex_a | r_id_ex_b;
         ALU_AND: w_ex_wdata = r_id_ex_a & r_id_ex_b;
         ALU_XOR: w_ex_wdata = r_id_ex_a ^ r_id_ex_b;
         ALU_NOR: w_ex_wdata = ~(r_id_ex_a | r_id_ex_b);
         ALU_ADD: w_ex_wdata = r_id_ex_a + r_id_ex_b;
         ALU_SUB: w_ex_wdata = r_id_ex_a - r_id_ex_b;
         ALU_SLT: w_ex_wdata = {31'd0, $signed(r_id_ex_a) < $signed(r_id_ex_b)};
         ALU_MUL: w_ex_wdata = w_prod;
         default: w_ex_wdata = '0;
      endcase
   end

   // MUL holds EX for one extra cycle; the counter marks the second cycle
   assign w_stall_ex = (r_id_ex_op == ALU_MUL) && !r_stall_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc           <= '0;
         r_if_id_inst   <= '0;
         r_id_ex_op     <= ALU_NOP;
         r_id_ex_a      <= '0;
         r_id_ex_b      <= '0;
         r_id_ex_wd     <= '0;
         r_id_ex_wreg   <= 1'b0;
         r_ex_mem_wdata <= '0;
         r_ex_mem_wd    <= '0;
         r_ex_mem_wreg  <= 1'b0;
         r_mem_wb_wdata <= '0;
         r_mem_wb_wd    <= '0;
         r_mem_wb_wreg  <= 1'b0;
         r_stall_cnt    <= 1'b0;
      end else begin
         r_stall_cnt <= w_stall_ex;
         if (!(w_stall_ex || w_stall_id)) begin
            r_pc         <= r_pc + 32'd4;
            r_if_id_inst <= rom.inst;
         end
         if (!w_stall_ex) begin
            if (w_stall_id) begin
               r_id_ex_op   <= ALU_NOP;
               r_id_ex_a    <= '0;
               r_id_ex_b    <= '0;
               r_id_ex_wd   <= '0;
               r_id_ex_wreg <= 1'b0;
            end else begin
               r_id_ex_op   <= w_aluop;
               r_id_ex_a    <= w_re1 ? w_src_a : 32'd0;
               r_id_ex_b    <= w_re2 ? w_src_b : w_imm_ext;
               r_id_ex_wd   <= w_wd;
               r_id_ex_wreg <= w_wreg;
            end
         end
         if (w_stall_ex) begin
            r_ex_mem_wdata <= '0;
            r_ex_mem_wd    <= '0;
            r_ex_mem_wreg  <= 1'b0;
         end else begin
            r_ex_mem_wdata <= w_ex_wdata;
            r_ex_mem_wd    <= r_id_ex_wd;
            r_ex_mem_wreg  <= r_id_ex_wreg;
         end
         r_mem_wb_wdata <= r_ex_mem_wdata;
         r_mem_wb_wd    <= r_ex_mem_wd;
         r_mem_wb_wreg  <= r_ex_mem_wreg;
      end
   end
endmodule

module min_sopc (
   input logic clk,
   input logic rst
);
   min_sopc_if w_rom_bus ();

   min_sopc_cpu cpu (
      .i_clk (clk),
      .i_rst (rst),
      .rom   (w_rom_bus.master)
   );

   min_sopc_inst_rom inst_rom0 (
      .rom (w_rom_bus.slave)
   );
endmodule

// File: tb/tb_min_sopc.sv
// Bench for min_sopc: programs are poked into the ROM, expected register commits are queued
// per edge and compared against the register file as the pipeline retires them.
module tb_min_sopc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

`ifdef MIN_SOPC_FORWARD_EN
   localparam int DEP = 1;
`else
   localparam int DEP = 3;
`endif

   localparam int OP_ORI  = 'h0D;
   localparam int OP_ANDI = 'h0C;
   localparam int OP_XORI = 'h0E;
   localparam int OP_LUI  = 'h0F;

   typedef struct {
      int          edge_n;
      int          rg;
      logic [31:0] val;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] prog[$];

   min_sopc dut (.clk(clk), .rst(rst));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] f_i(input int op, input int rs, input int rt, input int imm);
      logic [31:0] w;
      w = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
      return w;
   endfunction

   function automatic logic [31:0] f_r(input int rs, input int rt, input int rd, input int fn);
      logic [31:0] w;
      w = {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'h00, fn[5:0]};
      return w;
   endfunction

   function automatic logic [31:0] f_mul(input int rs, input int rt, input int rd);
      logic [31:0] w;
      w = {6'h1C, rs[4:0], rt[4:0], rd[4:0], 5'h00, 6'h02};
      return w;
   endfunction

   task automatic push(input int e, input int rg, input logic [31:0] v, input string t);
      exp_t x;
      x.edge_n = e; x.rg = rg; x.val = v; x.tag = t;
      sb.push_back(x);
   endtask

   task automatic load_rom();
      for (int i = 0; i < 1024; i++) dut.inst_rom0.inst_mem[i] = 32'h0;
      for (int i = 0; i < prog.size(); i++) dut.inst_rom0.inst_mem[i] = prog[i];
   endtask

   // Put the core in reset, load the program, release on a falling edge so the next rise is edge 1
   task automatic start_prog();
      rst = 1'b1;
      load_rom();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run(input int n_edges);
      exp_t x;
      for (int e = 1; e <= n_edges; e++) begin
         @(posedge clk);
         #1;
         while (sb.size() > 0 && sb[0].edge_n == e) begin
            x = sb.pop_front();
            check(x.tag, dut.cpu.register.storage[x.rg], x.val);
         end
      end
      if (sb.size() != 0) begin
         check("sb_drain", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   task automatic prog_ori3();
      prog.delete();
      prog.push_back(f_i(OP_ORI, 0, 1, 'h1234));
      prog.push_back(f_i(OP_ORI, 1, 1, 'h1234));
      prog.push_back(f_i(OP_ORI, 1, 1, 'h1234));
   endtask

   task automatic exp_ori3();
      push(4, 1, 32'h0, "p1_pre");
      push(5, 1, 32'h1234, "p1_e5");
      push(6, 1, 32'h1234, "p1_e6");
      push(14, 1, 32'h1234, "p1_final");
   endtask

   initial begin
      // reset state and first program
      prog_ori3();
      load_rom();
      @(negedge clk);
      @(negedge clk);
      check("rst_pc", dut.cpu.r_pc, 32'h0);
      check("rst_ifid", dut.cpu.r_if_id_inst, 32'h0);
      check("rst_fetch", dut.w_rom_bus.inst, 32'h0);
      check("rst_r1", dut.cpu.register.storage[1], 32'h0);
      check("rst_cnt", {31'd0, dut.cpu.r_stall_cnt}, 32'h0);
      rst = 1'b0;
      exp_ori3();
      run(14);

      // dependent chain ori/xor/ori
      prog.delete();
      prog.push_back(f_i(OP_ORI, 0, 1, 'h1234));
      prog.push_back(f_r(1, 1, 1, 'h26));
      prog.push_back(f_i(OP_ORI, 1, 1, 'h1234));
      start_prog();
      push(5, 1, 32'h1234, "p2_a");
      push(5 + DEP - 1, 1, 32'h1234, "p2_b_pre");
      push(5 + DEP, 1, 32'h0, "p2_b");
      push(5 + 2 * DEP - 1, 1, 32'h0, "p2_c_pre");
      push(5 + 2 * DEP, 1, 32'h1234, "p2_c");
      run(16);

      // MUL with one-cycle EX occupancy penalty
      prog.delete();
      prog.push_back(f_i(OP_ORI, 0, 2, 3));
      prog.push_back(f_i(OP_ORI, 0, 3, 5));
      prog.push_back(f_mul(2, 3, 1));
      prog.push_back(f_i(OP_ORI, 0, 4, 1));
      start_prog();
      push(5, 2, 32'd3, "p3_r2");
      push(6, 3, 32'd5, "p3_r3");
      push(5 + DEP + 2 - 1, 1, 32'd0, "p3_mul_pre");
      push(5 + DEP + 2, 1, 32'd15, "p3_mul");
      push(5 + DEP + 2, 4, 32'd0, "p3_r4_pre");
      push(5 + DEP + 3, 4, 32'd1, "p3_r4");
      run(18);

      // LUI then ORI, and a write to $0
      prog.delete();
      prog.push_back(f_i(OP_LUI, 0, 1, 'h89AB));
      prog.push_back(f_i(OP_ORI, 1, 1, 'h89AB));
      prog.push_back(f_i(OP_ORI, 0, 0, 'hFFFF));
      start_prog();
      push(5, 1, 32'h89AB0000, "p4_lui");
      push(5 + DEP, 1, 32'h89AB89AB, "p4_ori");
      push(5 + DEP + 2, 0, 32'h0, "p4_r0");
      run(14);

      // R-type / immediate coverage, signed compare, illegal encodings
      prog.delete();
      prog.push_back(f_i(OP_ORI, 0, 2, 'h00F0));
      prog.push_back(f_i(OP_ORI, 0, 3, 'h0FF0));
      prog.push_back(f_r(2, 3, 4, 'h24));
      prog.push_back(f_r(2, 3, 5, 'h25));
      prog.push_back(f_r(2, 3, 12, 'h26));
      prog.push_back(f_r(2, 3, 6, 'h27));
      prog.push_back(f_r(2, 3, 7, 'h21));
      prog.push_back(f_r(2, 3, 8, 'h23));
      prog.push_back(f_i(OP_ANDI, 3, 10, 'h00FF));
      prog.push_back(f_i(OP_XORI, 2, 11, 'hFFFF));
      prog.push_back(32'h0000_0000);
      prog.push_back(32'hFC0E_0000);
      prog.push_back(f_r(8, 2, 9, 'h2A));
      prog.push_back(f_r(2, 8, 13, 'h2A));
      start_prog();
      push(40, 4, 32'h000000F0, "p5_and");
      push(40, 5, 32'h00000FF0, "p5_or");
      push(40, 12, 32'h00000F00, "p5_xor");
      push(40, 6, 32'hFFFFF00F, "p5_nor");
      push(40, 7, 32'h000010E0, "p5_addu");
      push(40, 8, 32'hFFFFF100, "p5_subu");
      push(40, 10, 32'h000000F0, "p5_andi");
      push(40, 11, 32'h0000FF0F, "p5_xori");
      push(40, 14, 32'h0, "p5_illegal");
      push(40, 9, 32'd1, "p5_slt_neg");
      push(40, 13, 32'd0, "p5_slt_pos");
      run(40);

      // asynchronous reset mid-run, then timing repeats
      prog_ori3();
      start_prog();
      push(5, 1, 32'h1234, "p6_e5");
      push(6, 1, 32'h1234, "p6_e6");
      run(6);
      #3;
      rst = 1'b1;
      #1;
      check("arst_pc", dut.cpu.r_pc, 32'h0);
      check("arst_r1", dut.cpu.register.storage[1], 32'h0);
      check("arst_rom", dut.inst_rom0.inst_mem[0], prog[0]);
      @(negedge clk);
      rst = 1'b0;
      exp_ori3();
      run(14);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
